// File: rtl/lane_packer.sv
// rtl/lane_packer.sv - packs a scalar stream into NUM_LANES-lane wide words
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   s_tdata/s_tvalid/s_tlast/s_tready   scalar input stream, one lane per beat
//   m_tdata/m_tvalid/m_tlast/m_tready   packed output stream
//   m_tlanes          number of filled lanes in m_tdata (1..NUM_LANES)

module lane_packer #(
    parameter int unsigned LANE_WIDTH     = 16,
    parameter int unsigned NUM_LANES      = 16,
    parameter int unsigned OUT_DATA_WIDTH = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [LANE_WIDTH-1:0]         s_tdata,
    input  logic                          s_tvalid,
    input  logic                          s_tlast,
    output logic                          s_tready,
    output logic [OUT_DATA_WIDTH-1:0]     m_tdata,
    output logic                          m_tvalid,
    output logic                          m_tlast,
    output logic [$clog2(NUM_LANES):0]    m_tlanes,
    input  logic                          m_tready
);

    localparam int CNT_W = $clog2(NUM_LANES);
    localparam int TL_W  = CNT_W + 1;

    logic [OUT_DATA_WIDTH-1:0] pack_q;
    logic [CNT_W-1:0]          lane_cnt_q;
    logic [OUT_DATA_WIDTH-1:0] out_data_q;
    logic                      out_valid_q;
    logic                      out_last_q;
    logic [TL_W-1:0]           out_lanes_q;

    logic                      accept;
    logic                      completing;
    logic [OUT_DATA_WIDTH-1:0] merged;

    // The output register can take a new word when it is empty or being drained.
    assign s_tready   = !out_valid_q || m_tready;
    assign accept     = s_tvalid && s_tready;
    // NUM_LANES is a power of two, so the top lane index is all ones.
    assign completing = accept && ((&lane_cnt_q) || s_tlast);

    // Lanes at and above lane_cnt_q in pack_q are always zero because pack_q is
    // cleared on every completing beat, so the merge only has to insert one lane
    // and unused lanes of a short word come out zero without extra masking.
    always_comb begin
        merged = pack_q;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (lane_cnt_q == k[CNT_W-1:0]) begin
                merged[k*LANE_WIDTH +: LANE_WIDTH] = s_tdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pack_q      <= '0;
            lane_cnt_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_lanes_q <= '0;
        end else begin
            if (completing) begin
                out_data_q  <= merged;
                out_valid_q <= 1'b1;
                out_last_q  <= s_tlast;
                out_lanes_q <= TL_W'(lane_cnt_q) + TL_W'(1);
                pack_q      <= '0;
                lane_cnt_q  <= '0;
            end else begin
                if (accept) begin
                    pack_q     <= merged;
                    lane_cnt_q <= lane_cnt_q + CNT_W'(1);
                end
                // A drain with no replacement word empties the output register.
                if (out_valid_q && m_tready) begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

    assign m_tdata  = out_data_q;
    assign m_tvalid = out_valid_q;
    assign m_tlast  = out_last_q;
    assign m_tlanes = out_lanes_q;

endmodule
